axi_rd_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single AXI4 read master port (AR/R channels, 128-bit rdata) among
//  NUM_REQ internal read clients (frame-buffer readers, CNN weight/feature fetch, AHB bridge).
//  One burst is outstanding at a time. A grant covers the whole burst. Returned beats are steered
//  to the granted client. Response errors, RID/length mismatches and stalls are flagged.

---
 rtl/axi_arb_pkg.sv | 15 +
 rtl/axi_rd_arbiter_rr_pick.sv | 37 +++
 rtl/axi_rd_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared state encoding and AXI constants for the round-robin AXI read arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         AXI_ID_W       = 4;
  localparam int         AXI_DATA_W     = 128;

endpackage

// File: rtl/axi_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W:0]   j_wide;
  logic [IDX_W-1:0] j;
  logic             found;

  // NOTE: every output and temporary gets a default first, so no path leaves a latch.
  always_comb begin
    gnt_o  = '0;
    idx_o  = '0;
    found  = 1'b0;
    j_wide = '0;
    j      = '0;
    for (int i = 0; i < N; i++) begin
      j_wide = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (j_wide >= (IDX_W+1)'(N)) j_wide = j_wide - (IDX_W+1)'(N);
      j = j_wide[IDX_W-1:0];
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read master among NUM_REQ clients, one whole burst at a time, with
// round-robin grants, beat steering, response/length checking and a stall watchdog.
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*4-1:0]  req_len,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rd_valid,
  output logic [AXI_DATA_W-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_err,
  output logic                  len_err,
  output logic                  timeout_err,
  output logic                  busy,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [31:0]           araddr,
  output logic [AXI_ID_W-1:0]   arid,
  output logic [3:0]            arlen,
  output logic [1:0]            arburst,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [AXI_DATA_W-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic [AXI_ID_W-1:0]   rid,
  input  logic                  rlast
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d, gnt_q, gnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        len_q, len_d, beat_cnt_q, beat_cnt_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              err_sticky_q, err_sticky_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx, next_ptr;
  logic               pick_any, wd_term, beat_err;
  logic [31:0]        sel_addr;
  logic [3:0]         sel_len;

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_addr = req_addr[32*i +: 32];
        sel_len  = req_len[4*i +: 4];
      end
    end
  end

  assign next_ptr = (gnt_q == IDX_W'(NUM_REQ-1)) ? '0 : gnt_q + IDX_W'(1);
  assign wd_term  = (wd_cnt_q == WD_W'(TIMEOUT_CYCLES-1));
  assign beat_err = (rresp != AXI_RESP_OKAY) || (rid != AXI_ID_W'(gnt_q));

  // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      gnt_q        <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      wd_cnt_q     <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_q        <= gnt_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      beat_cnt_q   <= beat_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_d        = gnt_q;
    addr_d       = addr_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    wd_cnt_d     = wd_cnt_q;
    err_sticky_d = err_sticky_q;
    unique case (state_q)
      IDLE: begin
        wd_cnt_d = '0;
        if (pick_any) begin
          gnt_d   = pick_idx;
          addr_d  = sel_addr;
          len_d   = sel_len;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (arready) begin
          state_d      = DATA;
          rr_ptr_d     = next_ptr;
          beat_cnt_d   = '0;
          wd_cnt_d     = '0;
          err_sticky_d = 1'b0;
        end else if (wd_term) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      DATA: begin
        // A beat always beats the watchdog, so rlast on the terminal cycle never times out.
        if (rvalid) begin
          beat_cnt_d   = beat_cnt_q + 4'd1;
          wd_cnt_d     = '0;
          err_sticky_d = err_sticky_q | beat_err;
          if (rlast) state_d = IDLE;
        end else if (wd_term) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = '0;
    rd_valid    = '0;
    rd_last     = 1'b0;
    rd_err      = 1'b0;
    len_err     = 1'b0;
    timeout_err = 1'b0;
    unique case (state_q)
      IDLE: req_ready = pick_gnt;
      ADDR: timeout_err = !arready && wd_term;
      DATA: begin
        if (rvalid) begin
          rd_valid = NUM_REQ'(1) << gnt_q;
          rd_last  = rlast;
          rd_err   = rlast && (err_sticky_q || beat_err);
          len_err  = rlast && (beat_cnt_q != len_q);
        end else begin
          timeout_err = wd_term;
        end
      end
      default: ;
    endcase
  end

  assign arvalid = (state_q == ADDR);
  assign rready  = (state_q == DATA);
  assign busy    = (state_q != IDLE);
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arid    = AXI_ID_W'(gnt_q);
  assign arburst = AXI_BURST_INCR;
  assign rd_data = rdata;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: a table of single-client bursts plus hand-written
// sequences for round-robin order, watchdog abort and reset in mid-burst.
module tb_axi_rd_arbiter;

  localparam int NUM_REQ        = 4;
  localparam int TIMEOUT_CYCLES = 1024;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ*4-1:0]  req_len;
  logic [NUM_REQ-1:0]    req_ready, rd_valid;
  logic [127:0]          rd_data;
  logic                  rd_last, rd_err, len_err, timeout_err, busy;
  logic                  arvalid, arready;
  logic [31:0]           araddr;
  logic [3:0]            arid, arlen;
  logic [1:0]            arburst;
  logic                  rvalid, rready;
  logic [127:0]          rdata;
  logic [1:0]            rresp;
  logic [3:0]            rid;
  logic                  rlast;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int          c;
    logic [31:0] addr;
    logic [3:0]  len;
    int          nbeats;
    int          bad_beat;
    logic [1:0]  bad_resp;
    logic [3:0]  bad_id;
    bit          exp_rd_err;
    bit          exp_len_err;
  } burst_vec_t;

  burst_vec_t vecs[8];
  int         rr_order[5] = '{0, 1, 2, 3, 0};

  always #5 clk = ~clk;

  axi_rd_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_err(rd_err),
    .len_err(len_err), .timeout_err(timeout_err), .busy(busy),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arburst(arburst), .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rid(rid), .rlast(rlast)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_len   = '0;
    arready   = 1'b0;
    rvalid    = 1'b0;
    rdata     = '0;
    rresp     = 2'b00;
    rid       = '0;
    rlast     = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Starts and ends just after a rising edge; drop releases req_valid once granted.
  task automatic run_burst(input int c, input logic [31:0] addr, input logic [3:0] len,
                           input int nbeats, input int bad_beat, input logic [1:0] bad_resp,
                           input logic [3:0] bad_id, input bit exp_rd_err, input bit exp_len_err,
                           input bit drop);
    logic [NUM_REQ-1:0] exp_gnt;
    logic [127:0]       d;
    bit                 got;
    exp_gnt = NUM_REQ'(1) << c;
    req_addr[32*c +: 32] = addr;
    req_len[4*c +: 4]    = len;
    req_valid[c]         = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (req_ready != '0) got = 1'b1;
      else tick();
    end
    check("grant", 128'(req_ready), 128'(exp_gnt));
    if (!got) return;
    check("arvalid_in_req_cycle", 128'(arvalid), 128'(1'b0));
    tick();
    if (drop) req_valid[c] = 1'b0;
    arready = 1'b1;
    @(negedge clk);
    check("arvalid", 128'(arvalid), 128'(1'b1));
    check("araddr", 128'(araddr), 128'(addr));
    check("arlen", 128'(arlen), 128'(len));
    check("arid", 128'(arid), 128'(4'(c)));
    tick();
    arready = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      d      = {addr, 32'(b), ~addr, 32'hA5A5_0000 | 32'(b)};
      rvalid = 1'b1;
      rdata  = d;
      rresp  = (b == bad_beat) ? bad_resp : 2'b00;
      rid    = (b == bad_beat) ? bad_id : 4'(c);
      rlast  = (b == nbeats - 1);
      @(negedge clk);
      check("rready", 128'(rready), 128'(1'b1));
      check("rd_valid", 128'(rd_valid), 128'(exp_gnt));
      check("rd_data", rd_data, d);
      check("rd_last", 128'(rd_last), 128'(rlast));
      check("rd_err", 128'(rd_err), 128'(rlast ? exp_rd_err : 1'b0));
      check("len_err", 128'(len_err), 128'(rlast ? exp_len_err : 1'b0));
      tick();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    if (drop) begin
      @(negedge clk);
      check("busy_after_burst", 128'(busy), 128'(1'b0));
      check("len_err_pulse_end", 128'(len_err), 128'(1'b0));
      tick();
    end
  endtask

  initial begin
    bit bad;

    //           c  addr           len  nb  bad  resp   id    rd_err len_err
    vecs[0] = '{0, 32'h1000_0000, 4'd3,  4, -1, 2'b00, 4'd0, 1'b0, 1'b0};
    vecs[1] = '{2, 32'h2000_0040, 4'd1,  2,  1, 2'b10, 4'd2, 1'b1, 1'b0};
    vecs[2] = '{2, 32'h2000_0080, 4'd1,  2, -1, 2'b00, 4'd2, 1'b0, 1'b0};
    vecs[3] = '{1, 32'h3000_0000, 4'd3,  3, -1, 2'b00, 4'd1, 1'b0, 1'b1};
    vecs[4] = '{1, 32'h3000_0100, 4'd0,  1,  0, 2'b00, 4'd3, 1'b1, 1'b0};
    vecs[5] = '{3, 32'h4000_0000, 4'd2,  5, -1, 2'b00, 4'd3, 1'b0, 1'b1};
    vecs[6] = '{0, 32'h5000_0000, 4'd2,  3,  0, 2'b11, 4'd0, 1'b1, 1'b0};
    vecs[7] = '{2, 32'h6000_0000, 4'd15, 16, -1, 2'b00, 4'd2, 1'b0, 1'b0};

    do_reset();
    @(negedge clk);
    check("rst_busy", 128'(busy), 128'(1'b0));
    check("rst_arvalid", 128'(arvalid), 128'(1'b0));
    check("rst_rready", 128'(rready), 128'(1'b0));
    check("rst_req_ready", 128'(req_ready), 128'(4'b0000));
    check("rst_rd_valid", 128'(rd_valid), 128'(4'b0000));
    check("rst_araddr", 128'(araddr), 128'(32'h0));
    check("rst_arid_arlen", 128'({arid, arlen}), 128'(8'h00));
    check("rst_errs", 128'({rd_last, rd_err, len_err, timeout_err}), 128'(4'b0000));
    check("arburst", 128'(arburst), 128'(2'b01));
    tick();

    for (int v = 0; v < 8; v++) begin
      run_burst(vecs[v].c, vecs[v].addr, vecs[v].len, vecs[v].nbeats, vecs[v].bad_beat,
                vecs[v].bad_resp, vecs[v].bad_id, vecs[v].exp_rd_err, vecs[v].exp_len_err, 1'b1);
    end

    // All four clients request continuously: grants must rotate.
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      run_burst(rr_order[k], 32'h7000_0000 + 32'(rr_order[k] * 256), 4'd0, 1, -1, 2'b00,
                4'(rr_order[k]), 1'b0, 1'b0, 1'b0);
    end
    req_valid = '0;

    // Watchdog: arready never arrives for client 1.
    do_reset();
    req_valid = 4'b0010;
    req_addr[32 +: 32] = 32'h8000_0000;
    @(negedge clk);
    check("to_grant", 128'(req_ready), 128'(4'b0010));
    tick();
    req_valid = '0;
    bad = 1'b0;
    for (int n = 1; n < TIMEOUT_CYCLES; n++) begin
      @(negedge clk);
      if (timeout_err !== 1'b0 || arvalid !== 1'b1) bad = 1'b1;
      tick();
    end
    check("to_no_early_abort", 128'(bad), 128'(1'b0));
    @(negedge clk);
    check("to_pulse", 128'(timeout_err), 128'(1'b1));
    tick();
    @(negedge clk);
    check("to_pulse_width", 128'(timeout_err), 128'(1'b0));
    check("to_arvalid", 128'(arvalid), 128'(1'b0));
    check("to_busy", 128'(busy), 128'(1'b0));
    tick();
    req_valid = 4'b0110;
    @(negedge clk);
    check("to_rr_ptr", 128'(req_ready), 128'(4'b0100));

    // Reset while client 0's burst is in DATA.
    do_reset();
    req_valid = 4'b0001;
    req_len[3:0] = 4'd3;
    @(negedge clk);
    check("mr_grant", 128'(req_ready), 128'(4'b0001));
    tick();
    req_valid = '0;
    arready   = 1'b1;
    tick();
    arready = 1'b0;
    rvalid  = 1'b1;
    rid     = 4'd0;
    @(negedge clk);
    check("mr_beat", 128'(rd_valid), 128'(4'b0001));
    tick();
    rvalid = 1'b0;
    reset  = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("mr_rready", 128'(rready), 128'(1'b0));
    check("mr_busy", 128'(busy), 128'(1'b0));
    tick();
    req_valid = 4'b1000;
    #2;
    check("mr_req3_alone", 128'(req_ready), 128'(4'b1000));
    req_valid = 4'b1001;
    @(negedge clk);
    check("mr_rr_ptr_zero", 128'(req_ready), 128'(4'b0001));
    tick();
    req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
